// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter in front of a synchronous memory.
// Defining MEM_ARB_FIXED_PRIO_EN makes port A win every tie; otherwise ties go round-robin.
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic                gnt_b_q, gnt_b_d;
  logic                we_q, we_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                a_ack_q, a_ack_d;
  logic                b_ack_q, b_ack_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
  logic                grant_b;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic                last_b_q, last_b_d;
`endif

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign grant_b = !a_req;
`else
  assign grant_b = b_req && (!a_req || !last_b_q);
`endif

  always_comb begin
    state_d   = state_q;
    gnt_b_d   = gnt_b_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
    last_b_d  = last_b_q;
`endif
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          gnt_b_d = grant_b;
          we_d    = grant_b ? b_we : a_we;
          addr_d  = grant_b ? b_addr : a_addr;
          wdata_d = grant_b ? b_wdata : a_wdata;
          wr_d    = grant_b ? b_we : a_we;
          rd_d    = grant_b ? !b_we : !a_we;
`ifndef MEM_ARB_FIXED_PRIO_EN
          last_b_d = grant_b;
`endif
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        a_ack_d = !gnt_b_q;
        b_ack_d = gnt_b_q;
        state_d = RESP;
      end
      RESP: begin
        if (!we_q) begin
          if (gnt_b_q) b_rdata_d = mem_data_out;
          else         a_rdata_d = mem_data_out;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_b_q   <= 1'b0;
      we_q      <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_b_q  <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      gnt_b_q   <= gnt_b_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_b_q  <= last_b_d;
`endif
    end
  end

  // Memory read data only becomes valid during RESP, so it is passed through while ack is high.
  assign a_rdata     = (a_ack_q && !we_q) ? mem_data_out : a_rdata_q;
  assign b_rdata     = (b_ack_q && !we_q) ? mem_data_out : b_rdata_q;
  assign a_ack       = a_ack_q;
  assign b_ack       = b_ack_q;
  assign mem_read    = rd_q;
  assign mem_write   = wr_q;
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - transaction-level model check of mem_arbiter with directed and random traffic.
module tb_mem_arbiter;
  localparam int AW = 5;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic a_ack, b_ack, mem_read, mem_write, busy;
  logic [DW-1:0] a_rdata, b_rdata, mem_data_in;
  logic [DW-1:0] mem_data_out = '0;
  logic [AW-1:0] mem_addr;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors = 0;
  int cyc_n = 0;
  bit ack_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory the DUT drives
  logic [DW-1:0] mem [32];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_data_in;
    if (mem_read)  mem_data_out  <= mem[mem_addr];
  end

  // Reference: a transaction is (port, we, addr, wdata) and occupies 3 cycles
  int ph;
  bit t_b, t_we, last_b;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata, rd_a, rd_b;
  logic [DW-1:0] ref_mem [32];

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
  end

  always @(posedge clk) cyc_n++;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; t_b = 0; t_we = 0; t_addr = '0; t_wdata = '0;
      rd_a = '0; rd_b = '0; last_b = 1;
    end else if (ph == 0) begin
      if (a_req || b_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        t_b = !a_req;
`else
        t_b = (a_req && b_req) ? !last_b : b_req;
`endif
        last_b  = t_b;
        t_we    = t_b ? b_we : a_we;
        t_addr  = t_b ? b_addr : a_addr;
        t_wdata = t_b ? b_wdata : a_wdata;
        ph = 1;
      end
    end else if (ph == 1) begin
      if (t_we) ref_mem[t_addr] = t_wdata;
      ph = 2;
    end else begin
      if (!t_we) begin
        if (t_b) rd_b = ref_mem[t_addr];
        else     rd_a = ref_mem[t_addr];
      end
      ph = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic [DW-1:0] ea, eb;
      ea = (ph == 2 && !t_b && !t_we) ? ref_mem[t_addr] : rd_a;
      eb = (ph == 2 &&  t_b && !t_we) ? ref_mem[t_addr] : rd_b;
      chk("mem_write", mem_write, (ph == 1) && t_we);
      chk("mem_read",  mem_read,  (ph == 1) && !t_we);
      chk("mem_addr",  mem_addr,  t_addr);
      chk("mem_data_in", mem_data_in, t_wdata);
      chk("busy", busy, ph != 0);
      chk("a_ack", a_ack, (ph == 2) && !t_b);
      chk("b_ack", b_ack, (ph == 2) && t_b);
      chk("a_rdata", a_rdata, ea);
      chk("b_rdata", b_rdata, eb);
      chk("strobe_excl", mem_read && mem_write, 0);
      chk("ack_excl", a_ack && b_ack, 0);
      if (a_ack) ack_log.push_back(1'b0);
      if (b_ack) ack_log.push_back(1'b1);
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    a_req = 0; b_req = 0;
    rst_n = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {mem_read, mem_write}, 0);
    chk("rst_acks", {a_ack, b_ack}, 0);
    chk("rst_addr_data", {mem_addr, mem_data_in}, 0);
    chk("rst_rdata", {a_rdata, b_rdata}, 0);
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic wait_ack(input bit pb, output int c);
    c = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if ((pb ? b_ack : a_ack) === 1'b1) begin
        c = cyc_n;
        break;
      end
    end
    chk(pb ? "b_ack_timeout" : "a_ack_timeout", c >= 0, 1);
    @(posedge clk); #1;
    if (pb) b_req = 0; else a_req = 0;
  endtask

  int ca, cb, wa, wb;
  bit sa, sb;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // A writes 0xA5 to address 3
    a_we = 1; a_addr = 5'd3; a_wdata = 8'hA5; a_req = 1;
    @(negedge clk);
    @(negedge clk);
    chk("wr_strobe", {mem_write, mem_read}, 2'b10);
    chk("wr_addr", mem_addr, 3);
    chk("wr_data", mem_data_in, 8'hA5);
    @(negedge clk);
    chk("wr_ack", {a_ack, mem_write}, 2'b10);
    chk("wr_a_rdata", a_rdata, 0);
    @(posedge clk); #1; a_req = 0;

    // B reads it back
    b_we = 0; b_addr = 5'd3; b_req = 1;
    @(negedge clk);
    @(negedge clk);
    chk("rd_strobe", {mem_write, mem_read}, 2'b01);
    @(negedge clk);
    chk("rd_ack", b_ack, 1);
    chk("rd_b_rdata", b_rdata, 8'hA5);
    chk("rd_a_rdata", a_rdata, 0);
    @(posedge clk); #1; b_req = 0;

    // Simultaneous requests: A served first, B three cycles later
    do_reset();
    a_we = 1; a_addr = 5'd7; a_wdata = 8'h11; a_req = 1;
    b_we = 0; b_addr = 5'd7; b_req = 1;
    wait_ack(1'b0, ca);
    wait_ack(1'b1, cb);
    chk("tie_b_delay", cb - ca, 3);
    chk("tie_b_rdata", b_rdata, 8'h11);

    // Both held for four transactions
    do_reset();
    ack_log.delete();
    a_we = 1; a_addr = 5'd1; a_wdata = 8'h22; a_req = 1;
    b_we = 0; b_addr = 5'd1; b_req = 1;
    for (int i = 0; i < 16 && ack_log.size() < 4; i++) @(negedge clk);
    chk("hold_count", ack_log.size() >= 4, 1);
    if (ack_log.size() >= 4) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      chk("hold_order", {ack_log[0], ack_log[1], ack_log[2], ack_log[3]}, 4'b0000);
`else
      chk("hold_order", {ack_log[0], ack_log[1], ack_log[2], ack_log[3]}, 4'b0101);
`endif
    end

    // Reset during ACCESS of a write aborts it
    do_reset();
    a_we = 1; a_addr = 5'd9; a_wdata = 8'hFF; a_req = 1;
    @(negedge clk);
    @(posedge clk); #1;
    chk("abort_pre_strobe", mem_write, 1);
    rst_n = 0;
    a_req = 0;
    #1;
    chk("abort_strobe", {mem_write, mem_read}, 0);
    chk("abort_ack", a_ack, 0);
    @(posedge clk); #1;
    rst_n = 1;
    b_we = 0; b_addr = 5'd9; b_req = 1;
    wait_ack(1'b1, cb);
    chk("abort_readback", b_rdata, 0);

    // Random traffic
    do_reset();
    wa = 0; wb = 0;
    repeat (500) begin
      @(negedge clk);
      sa = a_ack; sb = b_ack;
      @(posedge clk); #1;
      if (sa) a_req = 0;
      if (sb) b_req = 0;
      wa = a_req ? wa + 1 : 0;
      wb = b_req ? wb + 1 : 0;
      if (a_req) chk("a_latency", wa <= 8, 1);
`ifndef MEM_ARB_FIXED_PRIO_EN
      if (b_req) chk("b_latency", wb <= 8, 1);
`endif
      if (!a_req && $urandom_range(0, 1) == 1) begin
        a_we = 1'($urandom); a_addr = AW'($urandom_range(0, 7)); a_wdata = DW'($urandom); a_req = 1;
      end
      if (!b_req && $urandom_range(0, 1) == 1) begin
        b_we = 1'($urandom); b_addr = AW'($urandom_range(0, 7)); b_wdata = DW'($urandom); b_req = 1;
      end
    end
    do_reset();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
